// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: radix-2 Booth shift-add multiplier sequencer with internal datapath.
// Revision 1.0
`default_nettype none

module booth_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 load,
  output logic                 alu_en,
  output logic                 alu_sel,
  output logic                 shift_en,
  output logic [CW-1:0]        cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   q_reg;
  logic               q_m1;
  logic [WIDTH-1:0]   m_reg;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] prod_r;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     acc_sh;
  logic [WIDTH-1:0]   q_sh;

  // Accumulator carries one guard bit so -(-2^(W-1)) stays representable.
  assign m_ext  = {m_reg[WIDTH-1], m_reg};
  assign acc_sh = {acc[WIDTH], acc[WIDTH:1]};
  assign q_sh   = {acc[0], q_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  state_next = S_EVAL;
      S_EVAL:  state_next = S_SHIFT;
      S_SHIFT: state_next = (cnt_r == CW'(1)) ? S_DONE : S_EVAL;
      S_DONE:  state_next = start ? S_LOAD : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      q_reg  <= '0;
      q_m1   <= 1'b0;
      m_reg  <= '0;
      cnt_r  <= '0;
      prod_r <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
          end
        end
        S_LOAD: begin
          acc   <= '0;
          q_m1  <= 1'b0;
          cnt_r <= CW'(WIDTH);
        end
        S_EVAL: begin
          if (q_reg[0] && !q_m1)      acc <= acc - m_ext;
          else if (!q_reg[0] && q_m1) acc <= acc + m_ext;
        end
        S_SHIFT: begin
          acc   <= acc_sh;
          q_reg <= q_sh;
          q_m1  <= q_reg[0];
          cnt_r <= cnt_r - CW'(1);
          // Final shift: capture the post-shift {A,Q} low 2W bits.
          if (cnt_r == CW'(1)) prod_r <= {acc_sh[WIDTH-1:0], q_sh};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    alu_en   = 1'b0;
    alu_sel  = 1'b0;
    shift_en = 1'b0;
    case (state)
      S_LOAD: begin
        busy = 1'b1;
        load = 1'b1;
      end
      S_EVAL: begin
        busy    = 1'b1;
        alu_en  = q_reg[0] ^ q_m1;
        alu_sel = !q_reg[0] && q_m1;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign product = prod_r;
  assign cnt     = cnt_r;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: directed and randomized checks of booth_seq_ctrl against a signed-product model.
`default_nettype none

module tb_booth_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic       load;
  logic       alu_en;
  logic       alu_sel;
  logic       shift_en;
  logic [2:0] cnt;

  int checks = 0;
  int errors = 0;

  booth_seq_ctrl #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .load         (load),
    .alu_en       (alu_en),
    .alu_sel      (alu_sel),
    .shift_en     (shift_en),
    .cnt          (cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 16'(busy), 16'd0);
    check({tag, ".done"}, 16'(done), 16'd0);
    check({tag, ".load"}, 16'(load), 16'd0);
    check({tag, ".alu_en"}, 16'(alu_en), 16'd0);
    check({tag, ".alu_sel"}, 16'(alu_sel), 16'd0);
    check({tag, ".shift_en"}, 16'(shift_en), 16'd0);
    check({tag, ".cnt"}, 16'(cnt), 16'd0);
    check({tag, ".product"}, 16'(product), 16'd0);
  endtask

  // One full operation, start sampled at the edge closing the current cycle.
  // Expected strobes follow Booth recoding: iteration i looks at {q[i], q[i-1]}, q[-1]=0.
  task automatic run_op(input logic [3:0] m, input logic [3:0] q);
    logic [7:0] expp;
    logic       qi, qm;
    int         it;
    expp = 8'(int'($signed(m)) * int'($signed(q)));
    start = 1'b1;
    multiplicand = m;
    multiplier = q;
    step();
    start = 1'b0;
    multiplicand = 4'($urandom);
    multiplier = 4'($urandom);
    for (int c = 1; c <= 10; c++) begin
      check("busy", 16'(busy), 16'(c <= 9));
      check("done", 16'(done), 16'(c == 10));
      check("load", 16'(load), 16'(c == 1));
      check("shift_en", 16'(shift_en), 16'(c >= 3 && c <= 9 && (c % 2) == 1));
      if (c >= 2 && c <= 9 && (c % 2) == 0) begin
        it = (c - 2) / 2;
        qi = q[it];
        qm = (it == 0) ? 1'b0 : q[it-1];
        check("alu_en", 16'(alu_en), 16'(qi != qm));
        check("alu_sel", 16'(alu_sel), 16'(!qi && qm));
      end else begin
        check("alu_en_idle", 16'(alu_en), 16'd0);
        check("alu_sel_idle", 16'(alu_sel), 16'd0);
      end
      if (c >= 2 && c <= 9) check("cnt", 16'(cnt), 16'(4 - (c - 2) / 2));
      else                  check("cnt_end", 16'(cnt), 16'd0);
      if (c == 10) check("product", 16'(product), 16'(expp));
      if (c < 10) step();
    end
  endtask

  initial begin
    logic [7:0] order [256];
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle");

    run_op(4'd3, 4'd5);
    for (int k = 0; k < 20; k++) begin
      step();
      check("hold_product", 16'(product), 16'h0F);
      check("hold_done", 16'(done), 16'd0);
    end

    run_op(4'hD, 4'd5);
    step();
    run_op(4'd7, 4'h8);
    step();
    run_op(4'h8, 4'h8);
    run_op(4'h0, 4'hF);
    step();

    // Start held high: a result every 10 cycles.
    start = 1'b1;
    multiplicand = 4'd2;
    multiplier = 4'd3;
    step();
    for (int c = 1; c <= 30; c++) begin
      check("b2b_done", 16'(done), 16'((c % 10) == 0));
      if ((c % 10) == 0) check("b2b_product", 16'(product), 16'h06);
      if (c == 30) start = 1'b0;
      step();
    end
    check("b2b_idle_busy", 16'(busy), 16'd0);

    // Abort with reset in cycle 5 of an operation.
    start = 1'b1;
    multiplicand = 4'd5;
    multiplier = 4'd6;
    step();
    start = 1'b0;
    for (int c = 1; c < 5; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("abort");
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_done", 16'(done), 16'd0);
      check("abort_busy", 16'(busy), 16'd0);
    end
    run_op(4'd5, 4'd6);
    step();

    // Exhaustive sweep in shuffled order, random idle gaps.
    for (int k = 0; k < 256; k++) order[k] = 8'(k);
    for (int k = 255; k > 0; k--) begin
      int j;
      logic [7:0] t;
      j = int'($urandom_range(k, 0));
      t = order[k];
      order[k] = order[j];
      order[j] = t;
    end
    for (int k = 0; k < 256; k++) begin
      run_op(order[k][7:4], order[k][3:0]);
      if ($urandom_range(1, 0) == 1) begin
        for (int g = int'($urandom_range(3, 1)); g > 0; g--) step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
